mp3_sci_reader: RTL and testbench
=================================

Name: mp3_sci_reader

Overview:
- SPI master for the VS10xx serial control interface (SCI) read path.
- Issues the SCI READ opcode (0x03) plus an 8-bit register address on SI, then shifts the 16-bit register value back in from SO.
- Sits beside the MP3 data-stream (SDI) logic. It lets game logic poll decoder status (SCI_STATUS, SCI_DECODE_TIME, SCI_HDAT0/1, SCI_VOL) through the otherwise-unused XCS line.

Parameters:
- CLK_DIV, 50, CLK cycles per SCLK half-period (100 MHz / (2*50) = 1 MHz SCLK); legal range 2..255.
- DREQ_TIMEOUT, 1000000, CLK cycles to wait for DREQ high before aborting with ERROR.

Ports:
- CLK  input  1  system clock, 100 MHz.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  one-cycle request; sampled only while BUSY=0.
- ADDRESS  input  8  SCI register address; captured on the accepted START.
- MP3_DREQ  input  1  decoder ready; high means the SCI may be accessed.
- MP3_SO  input  1  decoder serial data out.
- SCI_SCLK  output  1  SPI clock, idle low.
- MP3_CS  output  1  SCI chip select XCS, active low, idle high.
- SCI_SI  output  1  serial data to decoder, MSB first.
- BUSY  output  1  high from the accepted START until the inter-transaction gap ends.
- DATA_VALID  output  1  one-cycle pulse; RDATA is valid from this cycle on.
- RDATA  output  16  last register value read; held until the next DATA_VALID.
- ERROR  output  1  one-cycle pulse on DREQ timeout.

Behaviour:
- Reset values: SCI_SCLK=0, MP3_CS=1, SCI_SI=0, BUSY=0, DATA_VALID=0, RDATA=0, ERROR=0, state=IDLE.
- Reset mid-transaction aborts immediately: MP3_CS goes high asynchronously and no DATA_VALID is produced.
- States: IDLE -> WAIT_DREQ -> SHIFT -> CS_HOLD -> GAP -> IDLE.
- IDLE:
  - START=1 captures the 32-bit shift word {8'h03, ADDRESS, 16'h0000} and sets BUSY=1.
  - If MP3_DREQ=1 in the same cycle, go straight to SHIFT; otherwise go to WAIT_DREQ.
- WAIT_DREQ:
  - Counts CLK cycles. On MP3_DREQ=1, go to SHIFT next cycle.
  - When the count reaches DREQ_TIMEOUT: pulse ERROR, leave RDATA unchanged, enter GAP.
- SHIFT:
  - Entry cycle (call it T+1 when START was sampled at T with DREQ high): MP3_CS=0, SCI_SCLK=0, SCI_SI=bit31 (0).
  - Each half-period is exactly CLK_DIV cycles, counted by a down-counter; each SCLK period is low phase then high phase.
  - On every rising SCLK edge, MP3_SO is sampled into the LSB of the receive shift register.
  - On every falling SCLK edge, SI advances to the next bit.
  - Exactly 32 periods. Rising edges 1-16 carry the opcode and address; SO samples from edges 17-32 form RDATA[15:0], MSB first. Samples from edges 1-16 are discarded.
  - SI is driven 0 during data bits.
  - The 32nd falling edge occurs at T+1+64*CLK_DIV.
- CS_HOLD: SCLK low, CS low, for CLK_DIV cycles.
- At T+1+65*CLK_DIV: MP3_CS=1, RDATA updated, DATA_VALID pulses for one cycle. Enter GAP.
- GAP: CS high for CLK_DIV cycles (minimum XCS-high time). BUSY drops at T+1+66*CLK_DIV.
- A START while BUSY=1 is ignored and not queued.
- A START on the cycle BUSY falls is ignored. The earliest accepted START is the cycle after BUSY=0.
- MP3_DREQ is not re-checked once SHIFT has begun.
- ADDRESS changes after the accepted START have no effect.
- Counter widths: half-period counter 8 bits; bit counter 6 bits (0..32); timeout counter sized by $clog2(DREQ_TIMEOUT+1).

Decomposition:
- Shared package / include holds:
  - SCI opcode constants: SCI_OP_READ=8'h03, SCI_OP_WRITE=8'h02.
  - SCI register address constants: SCI_MODE=0x0, SCI_STATUS=0x1, SCI_CLOCKF=0x3, SCI_DECODE_TIME=0x4, SCI_HDAT0=0x8, SCI_HDAT1=0x9, SCI_VOL=0xB.
  - State encodings.
- One natural sub-module: sci_sclk_gen. It is the CLK_DIV half-period counter producing SCLK plus one-cycle rise_tick/fall_tick strobes, enabled only in SHIFT.

Test Plan:
- CLK_DIV=2, DREQ=1, decoder model returns 0x2020 for address 0x0B; START with ADDRESS=0x0B at T -> SI bit stream 0x030B0000, CS low T+1..T+130, DATA_VALID at T+131, RDATA=0x2020, BUSY low at T+133.
- DREQ held low for 40 cycles after START, then raised -> MP3_CS stays high until the cycle after DREQ rises; the transaction then completes with the correct RDATA.
- DREQ_TIMEOUT=100, DREQ held low -> ERROR pulses 100 cycles after START, CS never falls, RDATA keeps the previous value 0x2020.
- Second START pulsed 10 cycles into an active transaction with ADDRESS=0x04 -> ignored; only one DATA_VALID, and the captured address stays 0x0B.
- RESET asserted mid-SHIFT (after bit 20) -> CS=1 and SCLK=0 asynchronously, no DATA_VALID; a fresh read afterwards returns the correct value.
- Model drives 0xFFFF then 0x0001 on back-to-back reads started the cycle after BUSY falls -> RDATA=0xFFFF then 0x0001; CS-high gap is at least CLK_DIV cycles.

Source files
------------

// File: rtl/mp3_sci_reader_pkg.sv
// Shared constants, state encoding and frame builder for the VS10xx SCI read master.
package mp3_sci_reader_pkg;

    localparam logic [7:0] SCI_OP_READ     = 8'h03;
    localparam logic [7:0] SCI_OP_WRITE    = 8'h02;

    localparam logic [7:0] SCI_MODE        = 8'h00;
    localparam logic [7:0] SCI_STATUS      = 8'h01;
    localparam logic [7:0] SCI_CLOCKF      = 8'h03;
    localparam logic [7:0] SCI_DECODE_TIME = 8'h04;
    localparam logic [7:0] SCI_HDAT0       = 8'h08;
    localparam logic [7:0] SCI_HDAT1       = 8'h09;
    localparam logic [7:0] SCI_VOL         = 8'h0B;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DREQ = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_CS_HOLD   = 3'd3,
        ST_GAP       = 3'd4
    } sci_state_e;

    // Opcode and address go out first; the trailing 16 zero bits clock the reply in.
    function automatic logic [31:0] sci_read_frame(input logic [7:0] addr);
        return {SCI_OP_READ, addr, 16'h0000};
    endfunction

endpackage

// File: rtl/mp3_sci_reader_sci_sclk_gen.sv
// SCLK generator: CLK_DIV-cycle half periods, low phase first, with one-cycle edge strobes.
module sci_sclk_gen #(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam logic [7:0] HALF_M1 = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       sclk_q, sclk_d;

    // Strobes fire in the cycle whose closing edge toggles SCLK.
    always_comb begin
        cnt_d     = HALF_M1;
        sclk_d    = 1'b0;
        rise_tick = 1'b0;
        fall_tick = 1'b0;
        if (en) begin
            if (cnt_q == 8'd0) begin
                cnt_d     = HALF_M1;
                sclk_d    = ~sclk_q;
                rise_tick = ~sclk_q;
                fall_tick = sclk_q;
            end else begin
                cnt_d  = cnt_q - 8'd1;
                sclk_d = sclk_q;
            end
        end else begin
            cnt_d  = HALF_M1;
            sclk_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= HALF_M1;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;

endmodule

// File: rtl/mp3_sci_reader.sv
// VS10xx SCI read master: waits for DREQ, shifts READ+address out, captures 16-bit reply.
module mp3_sci_reader
    import mp3_sci_reader_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 50,
    parameter int unsigned DREQ_TIMEOUT = 1000000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [7:0]  ADDRESS,
    input  logic        MP3_DREQ,
    input  logic        MP3_SO,
    output logic        SCI_SCLK,
    output logic        MP3_CS,
    output logic        SCI_SI,
    output logic        BUSY,
    output logic        DATA_VALID,
    output logic [15:0] RDATA,
    output logic        ERROR
);

    localparam int unsigned    TO_W     = $clog2(DREQ_TIMEOUT + 1);
    localparam logic [7:0]     HALF_M1  = 8'(CLK_DIV - 1);
    localparam logic [TO_W-1:0] TO_FIRST = TO_W'(1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(DREQ_TIMEOUT - 1);

    sci_state_e      state_q, state_d;
    logic [31:0]     tx_q, tx_d;
    logic [15:0]     rx_q, rx_d;
    logic [5:0]      bit_q, bit_d;
    logic [7:0]      hold_q, hold_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            cs_q, cs_d;
    logic            busy_q, busy_d;
    logic            dv_q, dv_d;
    logic            err_q, err_d;
    logic [15:0]     rdata_q, rdata_d;

    logic sclk_s, rise_tick_s, fall_tick_s;

    sci_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk       (CLK),
        .rst       (RESET),
        .en        (state_q == ST_SHIFT),
        .sclk      (sclk_s),
        .rise_tick (rise_tick_s),
        .fall_tick (fall_tick_s)
    );

    // Next-state and output decode for the read sequence.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        bit_d   = bit_q;
        hold_d  = hold_q;
        to_d    = to_q;
        cs_d    = cs_q;
        busy_d  = busy_q;
        dv_d    = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    tx_d   = sci_read_frame(ADDRESS);
                    busy_d = 1'b1;
                    bit_d  = 6'd0;
                    to_d   = TO_FIRST;
                    if (MP3_DREQ) begin
                        state_d = ST_SHIFT;
                        cs_d    = 1'b0;
                    end else begin
                        state_d = ST_WAIT_DREQ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_DREQ: begin
                if (MP3_DREQ) begin
                    state_d = ST_SHIFT;
                    cs_d    = 1'b0;
                end else if (to_q >= TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_GAP;
                    hold_d  = HALF_M1;
                end else begin
                    to_d = to_q + TO_FIRST;
                end
            end
            ST_SHIFT: begin
                // Only the last 16 samples survive in rx, so opcode-phase samples drop out.
                if (rise_tick_s) begin
                    rx_d = {rx_q[14:0], MP3_SO};
                end else begin
                    rx_d = rx_q;
                end
                if (fall_tick_s) begin
                    tx_d  = {tx_q[30:0], 1'b0};
                    bit_d = bit_q + 6'd1;
                    if (bit_q == 6'd31) begin
                        state_d = ST_CS_HOLD;
                        hold_d  = HALF_M1;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    tx_d = tx_q;
                end
            end
            ST_CS_HOLD: begin
                if (hold_q == 8'd0) begin
                    state_d = ST_GAP;
                    hold_d  = HALF_M1;
                    cs_d    = 1'b1;
                    dv_d    = 1'b1;
                    rdata_d = rx_q;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            ST_GAP: begin
                if (hold_q == 8'd0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cs_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset releases XCS immediately.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            tx_q    <= 32'h0000_0000;
            rx_q    <= 16'h0000;
            bit_q   <= 6'd0;
            hold_q  <= 8'd0;
            to_q    <= '0;
            cs_q    <= 1'b1;
            busy_q  <= 1'b0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            bit_q   <= bit_d;
            hold_q  <= hold_d;
            to_q    <= to_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            dv_q    <= dv_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign SCI_SCLK   = sclk_s;
    assign MP3_CS     = cs_q;
    assign SCI_SI     = tx_q[31];
    assign BUSY       = busy_q;
    assign DATA_VALID = dv_q;
    assign RDATA      = rdata_q;
    assign ERROR      = err_q;

endmodule

// File: tb/tb_mp3_sci_reader.sv
// Directed bench for mp3_sci_reader with a small VS10xx SO responder.
module tb_mp3_sci_reader;
    import mp3_sci_reader_pkg::*;

    localparam int unsigned CLK_DIV      = 2;
    localparam int unsigned DREQ_TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  address;
    logic        dreq;
    logic        so;
    logic        sclk;
    logic        cs;
    logic        si;
    logic        busy;
    logic        dv;
    logic [15:0] rdata;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mp3_sci_reader #(
        .CLK_DIV      (CLK_DIV),
        .DREQ_TIMEOUT (DREQ_TIMEOUT)
    ) dut (
        .CLK        (clk),
        .RESET      (reset),
        .START      (start),
        .ADDRESS    (address),
        .MP3_DREQ   (dreq),
        .MP3_SO     (so),
        .SCI_SCLK   (sclk),
        .MP3_CS     (cs),
        .SCI_SI     (si),
        .BUSY       (busy),
        .DATA_VALID (dv),
        .RDATA      (rdata),
        .ERROR      (err)
    );

    // Decoder model: counts SCLK rises per frame, logs SI, drives the reply on edges 17..32.
    logic [15:0] resp = 16'h0000;
    logic [5:0]  rc = 6'd0;
    logic [31:0] si_word = 32'h0;
    logic [3:0]  so_idx;

    always @(posedge sclk or negedge cs) begin
        if (sclk) begin
            rc      <= rc + 6'd1;
            si_word <= {si_word[30:0], si};
        end else begin
            rc <= 6'd0;
        end
    end

    always_comb begin
        so_idx = 4'(6'd31 - rc);
        so     = (rc >= 6'd16 && rc < 6'd32) ? resp[so_idx] : 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int          r_first_cs, r_last_cs, r_dv_k, r_dv_cnt, r_err_k, r_err_cnt, r_busy_low;
    bit          r_done;
    logic [15:0] r_rdata;

    // One read starting at the current negedge; k counts cycles after the START sample.
    task automatic run_txn(input logic [7:0] addr, input logic [15:0] rv, input int dreq_at, input bit poke);
        r_first_cs = 0; r_last_cs = 0; r_dv_k = 0; r_dv_cnt = 0;
        r_err_k = 0; r_err_cnt = 0; r_busy_low = 0; r_done = 1'b0; r_rdata = 16'h0;
        resp    = rv;
        address = addr;
        start   = 1'b1;
        dreq    = (dreq_at == 0);
        for (int k = 1; k <= 400 && !r_done; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (poke && k == 10) begin
                start   = 1'b1;
                address = SCI_DECODE_TIME;
            end
            if (k == dreq_at) dreq = 1'b1;
            if (!cs) begin
                if (r_first_cs == 0) r_first_cs = k;
                r_last_cs = k;
            end
            if (dv) begin
                r_dv_cnt++;
                if (r_dv_k == 0) begin
                    r_dv_k  = k;
                    r_rdata = rdata;
                end
            end
            if (err) begin
                r_err_cnt++;
                if (r_err_k == 0) r_err_k = k;
            end
            if (!busy) begin
                r_busy_low = k;
                r_done     = 1'b1;
            end
        end
        chk("txn_done", 32'(r_done), 32'd1);
    endtask

    int prev_dv, prev_bl, dv_after;

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        address = 8'h00;
        dreq    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_sclk",  32'(sclk),  32'd0);
        chk("rst_cs",    32'(cs),    32'd1);
        chk("rst_si",    32'(si),    32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_dv",    32'(dv),    32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_err",   32'(err),   32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic read of SCI_VOL
        run_txn(SCI_VOL, 16'h2020, 0, 1'b0);
        chk("vol_cs_first", 32'(r_first_cs), 32'd1);
        chk("vol_cs_last",  32'(r_last_cs),  32'd130);
        chk("vol_dv_at",    32'(r_dv_k),     32'd131);
        chk("vol_dv_cnt",   32'(r_dv_cnt),   32'd1);
        chk("vol_rdata_dv", 32'(r_rdata),    32'h2020);
        chk("vol_busy_low", 32'(r_busy_low), 32'd133);
        chk("vol_si",       si_word,         32'h030B_0000);
        chk("vol_err_cnt",  32'(r_err_cnt),  32'd0);

        // DREQ never rises: timeout
        run_txn(SCI_STATUS, 16'h5555, -1, 1'b0);
        chk("to_err_at",   32'(r_err_k),    32'd100);
        chk("to_err_cnt",  32'(r_err_cnt),  32'd1);
        chk("to_cs_first", 32'(r_first_cs), 32'd0);
        chk("to_dv_cnt",   32'(r_dv_cnt),   32'd0);
        chk("to_rdata",    32'(rdata),      32'h2020);
        chk("to_busy_low", 32'(r_busy_low), 32'd102);
        dreq = 1'b1;

        // DREQ low for 40 cycles
        run_txn(SCI_DECODE_TIME, 16'h1357, 40, 1'b0);
        chk("dq_cs_first", 32'(r_first_cs), 32'd41);
        chk("dq_cs_last",  32'(r_last_cs),  32'd170);
        chk("dq_dv_at",    32'(r_dv_k),     32'd171);
        chk("dq_rdata",    32'(r_rdata),    32'h1357);
        chk("dq_busy_low", 32'(r_busy_low), 32'd173);
        chk("dq_si",       si_word,         32'h0304_0000);

        // Second START mid-transaction is ignored
        run_txn(SCI_VOL, 16'h2020, 0, 1'b1);
        chk("ig_dv_cnt",   32'(r_dv_cnt),   32'd1);
        chk("ig_si",       si_word,         32'h030B_0000);
        chk("ig_rdata",    32'(r_rdata),    32'h2020);
        chk("ig_busy_low", 32'(r_busy_low), 32'd133);
        chk("ig_cs_first", 32'(r_first_cs), 32'd1);

        // Back-to-back reads starting as soon as BUSY is low
        run_txn(SCI_HDAT0, 16'hFFFF, 0, 1'b0);
        chk("b2b_rdata0", 32'(r_rdata), 32'hFFFF);
        prev_dv = r_dv_k;
        prev_bl = r_busy_low;
        run_txn(SCI_HDAT1, 16'h0001, 0, 1'b0);
        chk("b2b_rdata1", 32'(r_rdata), 32'h0001);
        chk("b2b_si",     si_word,      32'h0309_0000);
        chk("b2b_gap",    32'((prev_bl - prev_dv) + r_first_cs), 32'd3);

        // Reset during SHIFT with SCLK high
        resp    = 16'hBEEF;
        address = SCI_CLOCKF;
        start   = 1'b1;
        for (int k = 1; k <= 91; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("mr_pre_cs",   32'(cs),   32'd0);
        chk("mr_pre_sclk", 32'(sclk), 32'd1);
        reset = 1'b1;
        #1;
        chk("mr_cs",    32'(cs),    32'd1);
        chk("mr_sclk",  32'(sclk),  32'd0);
        chk("mr_busy",  32'(busy),  32'd0);
        chk("mr_rdata", 32'(rdata), 32'd0);
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        dv_after = 0;
        for (int k = 0; k < 140; k++) begin
            @(negedge clk);
            if (dv) dv_after++;
        end
        chk("mr_no_dv", 32'(dv_after), 32'd0);

        // Fresh read after reset
        run_txn(SCI_MODE, 16'h4800, 0, 1'b0);
        chk("fr_rdata", 32'(r_rdata), 32'h4800);
        chk("fr_dv_at", 32'(r_dv_k),  32'd131);
        chk("fr_si",    si_word,      32'h0300_0000);
        chk("fr_port",  32'(rdata),   32'h4800);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
